// File: rtl/fsk_nco_pkg.sv
// Shared constants and types for the continuous-phase FSK oscillator.
// PRECISION is the single source of the phase/angle width used by both this
// block and the downstream sine lookup stage.
package fsk_nco_pkg;

    localparam int PRECISION = 25;
    localparam int FSK_SPS_W = 16;

    typedef enum logic {
        FSK_IDLE = 1'b0,
        FSK_RUN  = 1'b1
    } fsk_state_e;

    // Index of the last strobe of a symbol; a zero count behaves like one.
    function automatic logic [31:0] fsk_last_index(input logic [31:0] sps_in);
        logic [31:0] last_s;
        if (sps_in == 32'd0) begin
            last_s = 32'd0;
        end else begin
            last_s = sps_in - 32'd1;
        end
        return last_s;
    endfunction

endpackage

// File: rtl/fsk_nco_if.sv
// Symbol stream handshake into the FSK oscillator: one bit per transfer,
// transfer happens when sym_valid and sym_ready are both high at a clock edge.
interface fsk_nco_if;

    logic sym_valid;
    logic sym_bit;
    logic sym_ready;

    modport master (
        output sym_valid,
        output sym_bit,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_bit,
        output sym_ready
    );

endinterface

// File: rtl/fsk_phase_acc.sv
// Phase accumulator: adds the increment on each enabled cycle, wrapping
// modulo 2^WIDTH by simply dropping the adder carry. A synchronous clear
// returns the phase to zero.
module fsk_phase_acc #(
    parameter int WIDTH = fsk_nco_pkg::PRECISION
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] phase
);

    // Phase register: clear wins over advance, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= {WIDTH{1'b0}};
        end else if (clr) begin
            phase <= {WIDTH{1'b0}};
        end else if (en) begin
            phase <= phase + inc;
        end else begin
            phase <= phase;
        end
    end

endmodule

// File: rtl/fsk_nco.sv
// Continuous-phase FSK NCO. A one-entry hold register takes symbols from the
// handshake; the core loads the held symbol's frequency word and a strobe
// count, then advances the phase once per sample strobe. When the last strobe
// of a symbol finds the hold register full, the next symbol loads on the same
// edge so back-to-back symbols have no gap sample. Phase is never reset on a
// symbol boundary, which keeps the output phase-continuous.
module fsk_nco #(
    parameter int PRECISION = fsk_nco_pkg::PRECISION,
    parameter int SPS_W     = fsk_nco_pkg::FSK_SPS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    fsk_nco_if.slave             sym,
    input  logic [PRECISION-1:0] freq0_word,
    input  logic [PRECISION-1:0] freq1_word,
    input  logic [SPS_W-1:0]     sps,
    input  logic                 phase_clr,
    output logic [PRECISION-1:0] angle,
    output logic                 active,
    output logic                 sym_done
);

    import fsk_nco_pkg::*;

    localparam logic [SPS_W-1:0]     CNT_ZERO = {SPS_W{1'b0}};
    localparam logic [SPS_W-1:0]     CNT_ONE  = {{(SPS_W-1){1'b0}}, 1'b1};

    fsk_state_e           state_r;
    fsk_state_e           state_nxt_s;
    logic                 hold_full_r;
    logic                 hold_full_nxt_s;
    logic                 hold_bit_r;
    logic                 hold_bit_nxt_s;
    logic                 ready_r;
    logic                 active_r;
    logic                 sym_done_r;
    logic [PRECISION-1:0] inc_r;
    logic [PRECISION-1:0] inc_nxt_s;
    logic [SPS_W-1:0]     cnt_r;
    logic [SPS_W-1:0]     cnt_nxt_s;
    logic [SPS_W-1:0]     cnt_reload_s;
    logic [31:0]          last_index_s;
    logic                 accept_s;
    logic                 strobe_s;
    logic                 last_s;
    logic                 load_s;
    logic                 clr_s;
    logic [PRECISION-1:0] phase_s;

    // FSM next state plus the load/strobe/clear decisions that depend on it.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        clr_s       = 1'b0;
        strobe_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            FSK_IDLE: begin
                if (hold_full_r) begin
                    load_s      = 1'b1;
                    state_nxt_s = FSK_RUN;
                end else begin
                    clr_s       = phase_clr;
                    state_nxt_s = FSK_IDLE;
                end
            end
            FSK_RUN: begin
                strobe_s = sample_en;
                last_s   = sample_en & (cnt_r == CNT_ZERO);
                if (last_s) begin
                    load_s      = hold_full_r;
                    state_nxt_s = hold_full_r ? FSK_RUN : FSK_IDLE;
                end else begin
                    state_nxt_s = FSK_RUN;
                end
            end
            default: begin
                state_nxt_s = FSK_IDLE;
            end
        endcase
    end

    // Datapath next values: hold register, increment and strobe counter.
    always_comb begin
        accept_s     = sym.sym_valid & ready_r;
        last_index_s = fsk_last_index(32'(sps));
        cnt_reload_s = last_index_s[SPS_W-1:0];

        if (load_s) begin
            inc_nxt_s = hold_bit_r ? freq1_word : freq0_word;
        end else begin
            inc_nxt_s = inc_r;
        end

        if (load_s) begin
            cnt_nxt_s = cnt_reload_s;
        end else if (strobe_s && (cnt_r != CNT_ZERO)) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // An accept can only coincide with a load when the hold was already
        // empty, so letting the accept win never drops a symbol.
        if (accept_s) begin
            hold_full_nxt_s = 1'b1;
        end else if (load_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end

        if (accept_s) begin
            hold_bit_nxt_s = sym.sym_bit;
        end else begin
            hold_bit_nxt_s = hold_bit_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FSK_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Core, hold register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_r <= 1'b0;
            hold_bit_r  <= 1'b0;
            ready_r     <= 1'b1;
            inc_r       <= {PRECISION{1'b0}};
            cnt_r       <= CNT_ZERO;
            active_r    <= 1'b0;
            sym_done_r  <= 1'b0;
        end else begin
            hold_full_r <= hold_full_nxt_s;
            hold_bit_r  <= hold_bit_nxt_s;
            ready_r     <= ~hold_full_nxt_s;
            inc_r       <= inc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            active_r    <= (state_nxt_s == FSK_RUN);
            sym_done_r  <= last_s;
        end
    end

    fsk_phase_acc #(
        .WIDTH (PRECISION)
    ) u_phase_acc (
        .clk   (clk),
        .reset (reset),
        .en    (strobe_s),
        .clr   (clr_s),
        .inc   (inc_r),
        .phase (phase_s)
    );

    assign angle         = phase_s;
    assign active        = active_r;
    assign sym_done      = sym_done_r;
    assign sym.sym_ready = ready_r;

endmodule

// File: tb/tb_fsk_nco.sv
// Self-checking bench for fsk_nco: directed scenarios followed by a random
// run, all compared every cycle against a symbol-level reference model that
// tracks pending symbols, strobes remaining and the wrapped phase.
module tb_fsk_nco;

    import fsk_nco_pkg::*;

    localparam int    PW  = PRECISION;
    localparam int    SW  = FSK_SPS_W;
    localparam longint MOD = 64'd1 << PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_en;
    logic          phase_clr;
    logic [PW-1:0] freq0_word;
    logic [PW-1:0] freq1_word;
    logic [SW-1:0] sps;
    logic [PW-1:0] angle;
    logic          active;
    logic          sym_done;

    fsk_nco_if sif ();

    fsk_nco #(.PRECISION(PW), .SPS_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .sym        (sif),
        .freq0_word (freq0_word),
        .freq1_word (freq1_word),
        .sps        (sps),
        .phase_clr  (phase_clr),
        .angle      (angle),
        .active     (active),
        .sym_done   (sym_done)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     passed = 0;
    int     fails  = 0;
    string  tname  = "reset";
    int     strobe_period = 1;
    int     cyc = 0;
    int     done_seen = 0;
    int     act_seen  = 0;

    // Reference model state
    bit     m_pend[$];
    bit     m_run;
    longint m_word;
    int     m_left;
    longint m_phase;
    bit     m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tname, tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_pend.delete();
        m_run   = 1'b0;
        m_word  = 0;
        m_left  = 0;
        m_phase = 0;
        m_done  = 1'b0;
    endfunction

    function automatic void m_start();
        bit b;
        b      = m_pend.pop_front();
        m_word = b ? longint'(freq1_word) : longint'(freq0_word);
        m_left = (sps == 0) ? 1 : int'(sps);
        m_run  = 1'b1;
    endfunction

    // One clock edge of the symbol-level model, using pre-edge inputs.
    function automatic void m_edge();
        bit acc;
        acc    = sif.sym_valid && (m_pend.size() == 0);
        m_done = 1'b0;
        if (reset) begin
            m_reset();
            return;
        end
        if (!m_run) begin
            if (m_pend.size() > 0) m_start();
            else if (phase_clr) m_phase = 0;
        end else if (sample_en) begin
            m_phase = (m_phase + m_word) % MOD;
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                if (m_pend.size() > 0) m_start();
                else m_run = 1'b0;
            end
        end
        if (acc) m_pend.push_back(sif.sym_bit);
    endfunction

    task automatic cycle();
        if (strobe_period > 0) sample_en = ((cyc % strobe_period) == 0);
        @(posedge clk);
        m_edge();
        cyc++;
        #1;
        check("angle",     32'(angle),    32'(m_phase));
        check("active",    32'(active),   32'(m_run));
        check("sym_done",  32'(sym_done), 32'(m_done));
        check("sym_ready", 32'(sif.sym_ready), 32'(m_pend.size() == 0));
        if (sym_done === 1'b1) done_seen++;
        if (active === 1'b1) act_seen++;
    endtask

    task automatic send(input bit b);
        bit rdy;
        bit ok;
        ok = 1'b0;
        sif.sym_valid = 1'b1;
        sif.sym_bit   = b;
        for (int n = 0; n < 200; n++) begin
            rdy = (m_pend.size() == 0);
            cycle();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        sif.sym_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!m_run && m_pend.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic clear_phase();
        phase_clr = 1'b1;
        cycle();
        phase_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        sample_en     = 1'b0;
        phase_clr     = 1'b0;
        freq0_word    = '0;
        freq1_word    = '0;
        sps           = '0;
        sif.sym_valid = 1'b0;
        sif.sym_bit   = 1'b0;
        m_reset();

        // Reset state
        #12;
        check("angle",     32'(angle),         32'd0);
        check("active",    32'(active),        32'd0);
        check("sym_done",  32'(sym_done),      32'd0);
        check("sym_ready", 32'(sif.sym_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single symbol, bit 0, four strobes
        tname = "single";
        freq0_word = 25'h0100000;
        sps = 16'd4;
        strobe_period = 1;
        done_seen = 0;
        send(1'b0);
        wait_idle();
        check("final_angle", 32'(angle), 32'h0400000);
        check("done_pulses", 32'(done_seen), 32'd1);
        cycle();
        cycle();
        check("angle_holds", 32'(angle), 32'h0400000);

        // Wrap-around with bit 1
        tname = "wrap";
        clear_phase();
        check("cleared", 32'(angle), 32'd0);
        freq1_word = 25'h1000000;
        sps = 16'd3;
        done_seen = 0;
        send(1'b1);
        wait_idle();
        check("final_angle", 32'(angle), 32'h1000000);
        check("done_pulses", 32'(done_seen), 32'd1);

        // Back-to-back symbols with no gap
        tname = "b2b";
        clear_phase();
        sps = 16'd2;
        done_seen = 0;
        act_seen  = 0;
        send(1'b1);
        send(1'b0);
        send(1'b1);
        wait_idle();
        check("final_angle", 32'(angle), 32'h0200000);
        check("done_pulses", 32'(done_seen), 32'd3);
        check("active_cycles", 32'(act_seen), 32'd6);

        // Sparse strobes
        tname = "sparse";
        clear_phase();
        strobe_period = 5;
        sps = 16'd3;
        done_seen = 0;
        send(1'b0);
        wait_idle();
        check("final_angle", 32'(angle), 32'h0300000);
        check("done_pulses", 32'(done_seen), 32'd1);
        strobe_period = 1;

        // sps of zero behaves as one, then phase clear in idle and in run
        tname = "sps0_clr";
        clear_phase();
        sps = 16'd0;
        done_seen = 0;
        send(1'b0);
        wait_idle();
        check("one_step", 32'(angle), 32'h0100000);
        check("done_pulses", 32'(done_seen), 32'd1);
        clear_phase();
        check("idle_clear", 32'(angle), 32'd0);
        sps = 16'd2;
        send(1'b0);
        phase_clr = 1'b1;
        wait_idle();
        phase_clr = 1'b0;
        check("run_clr_ignored", 32'(angle), 32'h0200000);

        // Reset in the middle of a symbol
        tname = "mid_reset";
        clear_phase();
        sps = 16'd8;
        send(1'b0);
        for (int n = 0; n < 50; n++) begin
            if (m_run && m_left <= 6) break;
            cycle();
        end
        check("two_steps", 32'(angle), 32'h0200000);
        #2;
        reset = 1'b1;
        #1;
        check("angle",     32'(angle),         32'd0);
        check("active",    32'(active),        32'd0);
        check("sym_ready", 32'(sif.sym_ready), 32'd1);
        m_reset();
        cycle();
        @(negedge clk);
        reset = 1'b0;
        sps = 16'd2;
        send(1'b0);
        wait_idle();
        check("fresh_symbol", 32'(angle), 32'h0200000);

        // Randomised traffic against the model
        tname = "random";
        strobe_period = 0;
        for (int n = 0; n < 500; n++) begin
            sif.sym_valid = ($urandom_range(0, 2) != 0);
            sif.sym_bit   = 1'($urandom_range(0, 1));
            sample_en     = ($urandom_range(0, 3) != 0);
            phase_clr     = ($urandom_range(0, 7) == 0);
            sps           = SW'($urandom_range(0, 3));
            freq0_word    = PW'($urandom);
            freq1_word    = PW'($urandom);
            cycle();
        end
        sif.sym_valid = 1'b0;
        phase_clr     = 1'b0;
        strobe_period = 1;
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
